// File: rtl/fifo_queue_pkg.sv
// Shared defaults and storage-style names for fifo_queue.
// The optional FIFO_QUEUE_PROTOCOL_CHECK_EN checker lives in fifo_queue.sv.
package fifo_queue_pkg;

   localparam int unsigned DefaultQueueSize  = 8;
   localparam int unsigned DefaultPtrWidth   = 3;
   localparam int unsigned DefaultEntryWidth = 32;

   localparam string StorageLutram = "LUTRAM";
   localparam string StorageFlops  = "FLOPS";

endpackage

// File: rtl/fifo_queue_storage.sv
// Entry storage for fifo_queue: one synchronous write port, one asynchronous read port.
// STORAGE_TYPE picks an indexed array (LUTRAM) or a decoded register bank (FLOPS).
module fifo_queue_storage
   import fifo_queue_pkg::*;
#(
   parameter int unsigned DEPTH        = DefaultQueueSize,
   parameter int unsigned ADDR_WIDTH   = DefaultPtrWidth,
   parameter int unsigned DATA_WIDTH   = DefaultEntryWidth,
   parameter string       STORAGE_TYPE = StorageLutram
) (
   input  logic                  clk_in,
   input  logic                  wr_en_i,
   input  logic [ADDR_WIDTH-1:0] wr_addr_i,
   input  logic [DATA_WIDTH-1:0] wr_data_i,
   input  logic [ADDR_WIDTH-1:0] rd_addr_i,
   output logic [DATA_WIDTH-1:0] rd_data_o
);

   if (STORAGE_TYPE == StorageFlops) begin : g_flops
      logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q;

      always_ff @(posedge clk_in) begin
         for (int i = 0; i < DEPTH; i++) begin
            if (wr_en_i && (wr_addr_i == ADDR_WIDTH'(i))) begin
               mem_q[i] <= wr_data_i;
            end
         end
      end

      assign rd_data_o = mem_q[rd_addr_i];
   end else begin : g_lutram
      logic [DATA_WIDTH-1:0] mem_q [DEPTH];

      always_ff @(posedge clk_in) begin
         if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
         end
      end

      assign rd_data_o = mem_q[rd_addr_i];
   end

endmodule

// File: rtl/fifo_queue.sv
// First-word-fall-through FIFO with occupancy count and async active-high reset.
// Define FIFO_QUEUE_PROTOCOL_CHECK_EN to report writes while full and pops while empty.
module fifo_queue
   import fifo_queue_pkg::*;
#(
   parameter int unsigned QUEUE_SIZE                 = DefaultQueueSize,
   parameter int unsigned QUEUE_PTR_WIDTH_IN_BITS    = DefaultPtrWidth,
   parameter int unsigned SINGLE_ENTRY_WIDTH_IN_BITS = DefaultEntryWidth,
   parameter string       STORAGE_TYPE               = StorageLutram
) (
   input  logic                                  clk_in,
   input  logic                                  reset_in,
   output logic                                  is_empty_out,
   output logic                                  is_full_out,
   input  logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_in,
   input  logic                                  request_valid_in,
   output logic                                  issue_ack_out,
   output logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] request_out,
   output logic                                  request_valid_out,
   input  logic                                  issue_ack_in
);

   localparam int unsigned PtrW = QUEUE_PTR_WIDTH_IN_BITS;
   localparam int unsigned CntW = QUEUE_PTR_WIDTH_IN_BITS + 1;
   localparam logic [CntW-1:0] FullCount = CntW'(QUEUE_SIZE);

   logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
   logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CntW-1:0] count_q, count_d;
   logic            push, pop;
   logic [SINGLE_ENTRY_WIDTH_IN_BITS-1:0] head_data;

   assign is_empty_out      = (count_q == '0);
   assign is_full_out       = (count_q == FullCount);
   assign push              = request_valid_in & ~is_full_out;
   assign pop               = issue_ack_in & ~is_empty_out;
   assign issue_ack_out     = push;
   assign request_valid_out = ~is_empty_out;
   assign request_out       = is_empty_out ? '0 : head_data;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      case ({push, pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   always_ff @(posedge clk_in or posedge reset_in) begin
      if (reset_in) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   fifo_queue_storage #(
      .DEPTH       (QUEUE_SIZE),
      .ADDR_WIDTH  (PtrW),
      .DATA_WIDTH  (SINGLE_ENTRY_WIDTH_IN_BITS),
      .STORAGE_TYPE(STORAGE_TYPE)
   ) u_storage (
      .clk_in    (clk_in),
      .wr_en_i   (push),
      .wr_addr_i (wr_ptr_q),
      .wr_data_i (request_in),
      .rd_addr_i (rd_ptr_q),
      .rd_data_o (head_data)
   );

`ifdef FIFO_QUEUE_PROTOCOL_CHECK_EN
   always_ff @(posedge clk_in) begin
      if (!reset_in) begin
         if (request_valid_in && is_full_out) begin
            $display("%t fifo_queue ERROR: write attempted while full", $time);
         end
         if (issue_ack_in && is_empty_out) begin
            $display("%t fifo_queue ERROR: issue_ack_in while empty", $time);
         end
      end
   end
`else
   // Protocol checker compiled out.
`endif

endmodule

// File: tb/tb_fifo_queue.sv
// Directed self-checking bench for fifo_queue (default 8 x 32-bit configuration).
module tb_fifo_queue;

   logic        clk_in;
   logic        reset_in;
   logic        is_empty_out;
   logic        is_full_out;
   logic [31:0] request_in;
   logic        request_valid_in;
   logic        issue_ack_out;
   logic [31:0] request_out;
   logic        request_valid_out;
   logic        issue_ack_in;

   int checks = 0;
   int errors = 0;

   fifo_queue dut (
      .clk_in           (clk_in),
      .reset_in         (reset_in),
      .is_empty_out     (is_empty_out),
      .is_full_out      (is_full_out),
      .request_in       (request_in),
      .request_valid_in (request_valid_in),
      .issue_ack_out    (issue_ack_out),
      .request_out      (request_out),
      .request_valid_out(request_valid_out),
      .issue_ack_in     (issue_ack_in)
   );

   initial clk_in = 1'b0;
   always #5 clk_in = ~clk_in;

   // Advance one clock; inputs change 1ns after the rising edge.
   task automatic tick();
      @(posedge clk_in);
      #1;
   endtask

   task automatic test_reset();
      reset_in = 1'b1;
      request_in = '0;
      request_valid_in = 1'b0;
      issue_ack_in = 1'b0;
      #1;
      checks++;
      if (is_empty_out !== 1'b1) begin
         errors++; $display("FAIL reset_empty: got %b want 1", is_empty_out);
      end
      checks++;
      if (is_full_out !== 1'b0) begin
         errors++; $display("FAIL reset_full: got %b want 0", is_full_out);
      end
      checks++;
      if ({request_valid_out, request_out} !== 33'd0) begin
         errors++; $display("FAIL reset_out: got valid=%b data=%h want 0/0",
                            request_valid_out, request_out);
      end
      tick(); tick();
      reset_in = 1'b0;
      tick();
   endtask

   task automatic test_invalid_writes();
      for (int i = 0; i < 8; i++) begin
         request_in = 32'hFFFF_FFFE - 32'(i % 4);
         request_valid_in = 1'b0;
         issue_ack_in = (i >= 4);
         #1;
         checks++;
         if (request_valid_out !== 1'b0 || request_out !== 32'd0 || is_empty_out !== 1'b1 ||
             issue_ack_out !== 1'b0) begin
            errors++;
            $display("FAIL invalid_write[%0d]: got valid=%b data=%h empty=%b ack=%b want 0/0/1/0",
                     i, request_valid_out, request_out, is_empty_out, issue_ack_out);
         end
         tick();
      end
      issue_ack_in = 1'b0;
   endtask

   task automatic test_write_read();
      for (int i = 0; i < 4; i++) begin
         request_in = 32'hFFFF_FFFE - 32'(i);
         request_valid_in = 1'b1;
         #1;
         checks++;
         if (issue_ack_out !== 1'b1) begin
            errors++; $display("FAIL wr_ack[%0d]: got %b want 1", i, issue_ack_out);
         end
         tick();
         request_valid_in = 1'b0;
         request_in = 32'hDEAD_BEEF;
         #1;
         checks++;
         if (request_out !== 32'hFFFF_FFFE || request_valid_out !== 1'b1) begin
            errors++; $display("FAIL wr_head[%0d]: got %h/%b want fffffffe/1",
                               i, request_out, request_valid_out);
         end
         tick();
      end
      for (int i = 0; i < 4; i++) begin
         issue_ack_in = 1'b1;
         #1;
         checks++;
         if (request_out !== 32'hFFFF_FFFE - 32'(i)) begin
            errors++; $display("FAIL rd_data[%0d]: got %h want %h",
                               i, request_out, 32'hFFFF_FFFE - 32'(i));
         end
         tick();
      end
      issue_ack_in = 1'b0;
      #1;
      checks++;
      if (is_empty_out !== 1'b1 || request_out !== 32'd0) begin
         errors++; $display("FAIL wr_rd_end: got empty=%b data=%h want 1/0",
                            is_empty_out, request_out);
      end
   endtask

   task automatic test_read_empty();
      reset_in = 1'b1;
      tick();
      reset_in = 1'b0;
      for (int i = 0; i < 8; i++) begin
         issue_ack_in = 1'b1;
         #1;
         checks++;
         if ((request_out | 32'(request_valid_out)) !== 32'd0) begin
            errors++; $display("FAIL rd_empty[%0d]: got data=%h valid=%b want 0",
                               i, request_out, request_valid_out);
         end
         tick();
      end
      issue_ack_in = 1'b0;
   endtask

   task automatic test_full();
      for (int i = 0; i < 16; i++) begin
         request_in = 32'hFFFF_FFFE - 32'(i);
         request_valid_in = 1'b1;
         #1;
         checks++;
         if (issue_ack_out !== (i < 8)) begin
            errors++; $display("FAIL full_ack[%0d]: got %b want %b", i, issue_ack_out, i < 8);
         end
         tick();
      end
      checks++;
      if (is_full_out !== 1'b1) begin
         errors++; $display("FAIL full_flag: got %b want 1", is_full_out);
      end
      // Write while full with a simultaneous pop: the write must still be dropped.
      request_in = 32'h1234_5678;
      issue_ack_in = 1'b1;
      #1;
      checks++;
      if (issue_ack_out !== 1'b0 || request_out !== 32'hFFFF_FFFE) begin
         errors++; $display("FAIL full_push_pop: got ack=%b data=%h want 0/fffffffe",
                            issue_ack_out, request_out);
      end
      tick();
      request_valid_in = 1'b0;
      for (int i = 1; i < 8; i++) begin
         #1;
         checks++;
         if (request_out !== 32'hFFFF_FFFE - 32'(i) || is_full_out !== 1'b0) begin
            errors++; $display("FAIL full_drain[%0d]: got %h full=%b want %h/0",
                               i, request_out, is_full_out, 32'hFFFF_FFFE - 32'(i));
         end
         tick();
      end
      issue_ack_in = 1'b0;
      #1;
      checks++;
      if (is_empty_out !== 1'b1) begin
         errors++; $display("FAIL full_end_empty: got %b want 1", is_empty_out);
      end
   endtask

   task automatic test_wrap();
      logic [31:0] model[$];
      for (int i = 0; i < 3; i++) begin
         request_in = 32'hA000_0000 + 32'(i);
         request_valid_in = 1'b1;
         model.push_back(request_in);
         tick();
      end
      for (int i = 0; i < 20; i++) begin
         request_in = 32'hB000_0000 + 32'(i);
         request_valid_in = 1'b1;
         issue_ack_in = 1'b1;
         #1;
         checks++;
         if (request_out !== model[0] || issue_ack_out !== 1'b1 || is_full_out !== 1'b0 ||
             is_empty_out !== 1'b0) begin
            errors++; $display("FAIL wrap[%0d]: got %h ack=%b full=%b empty=%b want %h/1/0/0",
                               i, request_out, issue_ack_out, is_full_out, is_empty_out,
                               model[0]);
         end
         model.push_back(request_in);
         void'(model.pop_front());
         tick();
      end
      request_valid_in = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++;
         if (request_out !== model[0]) begin
            errors++; $display("FAIL wrap_drain[%0d]: got %h want %h", i, request_out, model[0]);
         end
         void'(model.pop_front());
         tick();
      end
      issue_ack_in = 1'b0;
      #1;
      checks++;
      if (is_empty_out !== 1'b1) begin
         errors++; $display("FAIL wrap_end_empty: got %b want 1", is_empty_out);
      end
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 5; i++) begin
         request_in = 32'hC000_0000 + 32'(i);
         request_valid_in = 1'b1;
         tick();
      end
      request_valid_in = 1'b0;
      #2;
      reset_in = 1'b1;
      #1;
      checks++;
      if (is_empty_out !== 1'b1 || request_valid_out !== 1'b0 || request_out !== 32'd0) begin
         errors++; $display("FAIL reset_mid: got empty=%b valid=%b data=%h want 1/0/0",
                            is_empty_out, request_valid_out, request_out);
      end
      tick();
      reset_in = 1'b0;
      request_in = 32'h5555_AAAA;
      request_valid_in = 1'b1;
      tick();
      request_valid_in = 1'b0;
      #1;
      checks++;
      if (request_out !== 32'h5555_AAAA || request_valid_out !== 1'b1) begin
         errors++; $display("FAIL reset_mid_after: got %h/%b want 5555aaaa/1",
                            request_out, request_valid_out);
      end
   endtask

   initial begin
      test_reset();
      test_invalid_writes();
      test_write_read();
      test_read_empty();
      test_full();
      test_wrap();
      test_reset_mid();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/fifo_queue.md
FIFO_QUEUE -- requirements
Module: fifo_queue

Interface
REQ-001 SHALL have parameter QUEUE_SIZE, default 8: number of entries; must equal 2**QUEUE_PTR_WIDTH_IN_BITS.
REQ-002 SHALL have parameter QUEUE_PTR_WIDTH_IN_BITS, default 3: read/write pointer width.
REQ-003 SHALL have parameter SINGLE_ENTRY_WIDTH_IN_BITS, default 32: entry width.
REQ-004 SHALL have parameter STORAGE_TYPE, default "LUTRAM": storage style hint, "LUTRAM" or "FLOPS"; it has no functional effect.
REQ-005 SHALL have port clk_in, input, 1 bit: clock, all state updates on its rising edge.
REQ-006 SHALL have port reset_in, input, 1 bit: reset, asynchronous, active-high.
REQ-007 SHALL have port is_empty_out, output, 1 bit: queue holds zero entries.
REQ-008 SHALL have port is_full_out, output, 1 bit: queue holds QUEUE_SIZE entries.
REQ-009 SHALL have port request_in, input, SINGLE_ENTRY_WIDTH_IN_BITS: write data.
REQ-010 SHALL have port request_valid_in, input, 1 bit: write request.
REQ-011 SHALL have port issue_ack_out, output, 1 bit: write accepted this cycle.
REQ-012 SHALL have port request_out, output, SINGLE_ENTRY_WIDTH_IN_BITS: head entry.
REQ-013 SHALL have port request_valid_out, output, 1 bit: request_out is valid.
REQ-014 SHALL have port issue_ack_in, input, 1 bit: consumer pops the head entry.

Function
REQ-015 SHALL assert issue_ack_out combinationally when request_valid_in=1 and is_full_out=0; a write occurs at the clock edge where issue_ack_out=1.
REQ-016 SHALL drop a write when full: no state change, issue_ack_out=0, even if a pop happens in the same cycle.
REQ-017 SHALL ignore request_in whenever request_valid_in=0.
REQ-018 SHALL operate first-word-fall-through: request_valid_out = ~is_empty_out, and request_out = oldest entry.
REQ-019 SHALL drive request_out to all zeros whenever the queue is empty.
REQ-020 SHALL pop the head at a clock edge where issue_ack_in=1 and request_valid_out=1; issue_ack_in while empty is ignored.
REQ-021 SHALL present a written entry on request_out one cycle after its write edge, when it is at the head.
REQ-022 SHALL allow a simultaneous push and pop when 0 < count < QUEUE_SIZE: count is unchanged and both pointers advance.
REQ-023 SHALL advance pointers modulo QUEUE_SIZE (natural wrap-around) and keep an occupancy count of QUEUE_PTR_WIDTH_IN_BITS+1 bits.
REQ-024 SHALL derive is_empty_out (count==0) and is_full_out (count==QUEUE_SIZE) from registered state only.
REQ-025 SHALL output entries in exact write order with no duplication or loss of accepted entries.

Reset
REQ-026 SHALL on reset_in=1 immediately clear pointers and count: is_empty_out=1, is_full_out=0, request_valid_out=0, request_out=0.
REQ-027 SHALL, when reset asserts mid-operation, discard all stored entries; storage contents need not be cleared.

Configuration
REQ-028 SHALL, with FIFO_QUEUE_PROTOCOL_CHECK_EN defined, emit a simulation $display error on each write attempt while full and on each issue_ack_in while empty.
REQ-029 SHALL, without FIFO_QUEUE_PROTOCOL_CHECK_EN, compile no checker logic, with identical functional behaviour.

Structure
REQ-030 SHALL place the default width/size constants and the STORAGE_TYPE string constants in shared package fifo_queue_pkg.
REQ-031 SHALL implement storage in one sub-module fifo_queue_storage (1 write port, 1 async read port), selected by STORAGE_TYPE.

Verification
REQ-032 SHALL cover invalid writes: 4 cycles of request_in=FFFFFFFE..FFFFFFFB with request_valid_in=0, then 4 acks -> request_valid_out=0, request_out=0, is_empty_out=1 throughout.
REQ-033 SHALL cover normal write/read: write FFFFFFFE..FFFFFFFB, one every other cycle, then pop 4 -> outputs appear in the same order and the queue ends empty.
REQ-034 SHALL cover reading an empty queue: issue_ack_in=1 for 8 cycles after reset -> request_out|request_valid_out=0 every cycle.
REQ-035 SHALL cover writes to a full queue: 16 back-to-back writes FFFFFFFE downward -> first 8 acknowledged, is_full_out=1, last 8 have issue_ack_out=0; popping 8 returns FFFFFFFE..FFFFFFF7, then is_empty_out=1.
REQ-036 SHALL cover wrap-around: 20 cycles of simultaneous push and pop at count 3 -> order preserved and count stays 3.
REQ-037 SHALL cover reset with 5 entries stored -> is_empty_out=1 and request_valid_out=0 with no clock edge needed.
